// File: rtl/key_mode_ctrl.sv
// Pushbutton front end for the pattern register: sync, debounce,
// mode select stepping and the pattern step strobe.
module key_mode_ctrl #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TICK_DIV   = 5,
    parameter logic [2:0]  MODE_MAX   = 3'd5
) (
    input  logic       CLK_TOP,
    input  logic       RST_TOP,
    input  logic       KEY_IN,
    output logic [2:0] S_TOP,
    output logic       STEP_EN,
    output logic       KEY_PULSE
);

    localparam int unsigned CW = $clog2(DEB_CYCLES);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PC_LAST  = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_REL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [2:0]    s_q, s_d;
    logic          k1_q, k2_q;
    logic          step_q, step_d;
    logic          pulse_q, pulse_d;
    logic          accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (k2_q) begin
                    state_d = DEB_PRESS;
                    cnt_d   = CW'(1);
                end
            end
            DEB_PRESS: begin
                if (!k2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!k2_q) begin
                    state_d = DEB_REL;
                    cnt_d   = CW'(1);
                end
            end
            DEB_REL: begin
                if (k2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A new mode restarts the step period so the pattern begins cleanly.
    always_comb begin
        pc_d    = (pc_q == PC_LAST) ? '0 : pc_q + PW'(1);
        step_d  = (pc_q == PC_LAST);
        s_d     = s_q;
        pulse_d = accept;
        if (accept) begin
            pc_d   = '0;
            step_d = 1'b0;
            s_d    = (s_q == MODE_MAX) ? 3'd1 : s_q + 3'd1;
        end
    end

    always_ff @(posedge CLK_TOP) begin
        if (RST_TOP) begin
            k1_q    <= 1'b0;
            k2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            s_q     <= 3'd1;
            step_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            k1_q    <= KEY_IN;
            k2_q    <= k1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            s_q     <= s_d;
            step_q  <= step_d;
            pulse_q <= pulse_d;
        end
    end

    assign S_TOP     = s_q;
    assign STEP_EN   = step_q;
    assign KEY_PULSE = pulse_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed vector bench for key_mode_ctrl with default parameters.
// Each vector is one clock; outputs are checked 1 ns after the edge.
module tb_key_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic [2:0] s;
    logic       step;
    logic       pulse;

    always #5 clk = ~clk;

    key_mode_ctrl dut (
        .CLK_TOP  (clk),
        .RST_TOP  (rst),
        .KEY_IN   (key),
        .S_TOP    (s),
        .STEP_EN  (step),
        .KEY_PULSE(pulse)
    );

    typedef struct {
        string      tag;
        bit         rst;
        bit         key;
        logic [2:0] s;
        int         step;
        bit         pulse;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nbad = 0;

    function automatic void add(input string t, input bit r, input bit k,
                                input logic [2:0] es, input int est,
                                input bit ep);
        vec_t v;
        v.tag   = t;
        v.rst   = r;
        v.key   = k;
        v.s     = es;
        v.step  = est;
        v.pulse = ep;
        tbl.push_back(v);
    endfunction

    // est = -1 leaves STEP_EN unchecked for that cycle.
    task automatic cyc(input string t, input int idx, input bit r,
                       input bit k, input logic [2:0] es, input int est,
                       input bit ep);
        @(negedge clk);
        rst = r;
        key = k;
        @(posedge clk);
        #1;
        nvec++;
        if (s !== es || pulse !== ep ||
            (est != -1 && step !== (est == 1))) begin
            nbad++;
            $display("FAIL %s[%0d]: got S=%0d STEP=%b PULSE=%b, want S=%0d STEP=%0d PULSE=%b",
                     t, idx, s, step, pulse, es, est, ep);
        end
    endtask

    logic [2:0] wrapseq [5];
    logic [2:0] prev;

    initial begin
        rst = 1'b1;
        key = 1'b0;
        wrapseq[0] = 3'd2;
        wrapseq[1] = 3'd3;
        wrapseq[2] = 3'd4;
        wrapseq[3] = 3'd5;
        wrapseq[4] = 3'd1;

        // Reset, free-running prescaler, then a clean 20-cycle press
        // first sampled at edge 17: accept at 22, steps every 5 after.
        add("rst", 1'b1, 1'b0, 3'd1, 0, 1'b0);
        add("rst", 1'b1, 1'b0, 3'd1, 0, 1'b0);
        for (int e = 1; e <= 45; e++) begin
            add("press", 1'b0, (e >= 17 && e <= 36),
                (e >= 22) ? 3'd2 : 3'd1,
                ((e % 5 == 0 && e <= 20) ||
                 (e >= 27 && (e - 27) % 5 == 0)) ? 1 : 0,
                (e == 22));
        end

        // Accept on terminal count (edge 10), second press to 3,
        // then reset during DEB_PRESS at edge 54 with the key held.
        add("rst2", 1'b1, 1'b0, 3'd1, 0, 1'b0);
        for (int e = 1; e <= 65; e++) begin
            add("tc_rst", (e == 54),
                (e >= 5 && e <= 20) || (e >= 31 && e <= 40) || (e >= 51),
                (e < 10) ? 3'd1 : (e < 36) ? 3'd2 :
                (e < 54) ? 3'd3 : (e < 60) ? 3'd1 : 3'd2,
                (e inside {5, 15, 20, 25, 30, 35, 41, 46, 51, 59, 65}) ? 1 : 0,
                (e == 10 || e == 36 || e == 60));
        end

        foreach (tbl[i])
            cyc(tbl[i].tag, i, tbl[i].rst, tbl[i].key, tbl[i].s,
                tbl[i].step, tbl[i].pulse);

        // Glitch of 3 high cycles must be rejected.
        cyc("rst3", 0, 1'b1, 1'b0, 3'd1, 0, 1'b0);
        for (int j = 1; j <= 15; j++)
            cyc("glitch", j, 1'b0, (j >= 3 && j <= 5), 3'd1, -1, 1'b0);

        // Five presses, 8 high + 10 low, accept on the 6th high cycle.
        prev = 3'd1;
        for (int p = 0; p < 5; p++) begin
            for (int j = 1; j <= 18; j++)
                cyc("wrap", p * 18 + j, 1'b0, (j <= 8),
                    (j >= 6) ? wrapseq[p] : prev, -1, (j == 6));
            prev = wrapseq[p];
        end

        // Bounce: high 2, low 1, high 3, low 1, stable from cycle 8.
        cyc("rst4", 0, 1'b1, 1'b0, 3'd1, 0, 1'b0);
        for (int j = 1; j <= 30; j++)
            cyc("bounce", j, 1'b0,
                (j inside {1, 2, 4, 5, 6}) || (j >= 8 && j <= 20),
                (j >= 13) ? 3'd2 : 3'd1, -1, (j == 13));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/key_mode_ctrl.md
# key_mode_ctrl

Upstream control stage for the 8-bit pattern register (`top_register_8`). It turns a raw, bouncing pushbutton into a debounced one-cycle press pulse. Each accepted press advances the 3-bit mode select that drives the register's `S_TOP` input. It also generates the slow `STEP_EN` strobe that paces the register's pattern updates, so the pattern visibly steps at a fixed rate and restarts cleanly on every mode change.

## Interface
Parameters:
- `DEB_CYCLES`, 4: number of consecutive identical synchronized samples needed to accept a press or a release (≥2).
- `TICK_DIV`, 5: `STEP_EN` period in clock cycles (≥2).
- `MODE_MAX`, 3'd5: highest mode value. Modes run 3'd1..`MODE_MAX`; 3'd0 is never produced.

Ports:
- `CLK_TOP`, in, 1: single clock. All logic runs on its rising edge.
- `RST_TOP`, in, 1: reset, synchronous, active-high.
- `KEY_IN`, in, 1: raw pushbutton, active-high, asynchronous to `CLK_TOP`.
- `S_TOP`, out, 3: registered mode select, fed to the pattern register's `S_TOP`.
- `STEP_EN`, out, 1: registered one-cycle pattern-step strobe.
- `KEY_PULSE`, out, 1: registered one-cycle pulse per accepted press.

## Operation
- **Synchronizer:** `KEY_IN` passes through two flops, `k1` then `k2`. Both flops reset to 0. Only `k2` is used downstream.
- **Debounce FSM states and transitions:**
  - IDLE: on `k2`=1, go to DEB_PRESS with `cnt`=1.
  - DEB_PRESS:
    - `k2`=0: back to IDLE, `cnt`=0.
    - `k2`=1 and `cnt`<`DEB_CYCLES`-1: increment `cnt`.
    - `k2`=1 and `cnt`=`DEB_CYCLES`-1: go to HELD, `cnt`=0. This transition is the *accept* event.
  - HELD: on `k2`=0, go to DEB_REL with `cnt`=1.
  - DEB_REL:
    - `k2`=1: back to HELD, `cnt`=0.
    - `k2`=0 and `cnt`=`DEB_CYCLES`-1: go to IDLE, `cnt`=0.
    - otherwise: increment `cnt`.
- **Accept event:** on the same clock edge, `KEY_PULSE`←1 for exactly one cycle, and `S_TOP`←`S_TOP`+1. If `S_TOP`=`MODE_MAX`, it wraps to 3'd1 instead.
- **Single pulse per press:** holding the key any length produces one pulse. A new pulse requires a debounced release (IDLE) first.
- **Prescaler:** counter `pc` counts 0..`TICK_DIV`-1 and then wraps.
  - `STEP_EN`←1 on the edge where `pc`=`TICK_DIV`-1, otherwise `STEP_EN`←0.
  - On an accept event, `pc`←0 and `STEP_EN`←0, even if `pc` was at terminal count. The new mode therefore starts with a full period.
- **Reset** (`RST_TOP` sampled 1), all applied at the edge:
  - `S_TOP`=3'd1, `KEY_PULSE`=0, `STEP_EN`=0.
  - FSM=IDLE, `cnt`=0, `pc`=0, `k1`=`k2`=0.
  - Reset overrides everything, including mid-debounce and HELD states. If the key is still held after reset, it is debounced from IDLE and produces a new pulse.
- **Widths:** `cnt` and `pc` are sized by `$clog2` of their parameters. They are never compared outside their ranges.

## Timing
- Let edge N be the first edge sampling `KEY_IN`=1, with the key stable afterwards.
  - `k2`=1 after edge N+1.
  - Accept occurs at edge N+1+`DEB_CYCLES`.
  - `KEY_PULSE` and the new `S_TOP` are visible after that edge (N+5 with defaults).
- Release latency is symmetric: IDLE is reached at edge M+1+`DEB_CYCLES`, where M is the first edge sampling `KEY_IN`=0.
- **`STEP_EN` timing:**
  - After reset deasserts, the first `STEP_EN` is high after the `TICK_DIV`-th edge with `RST_TOP`=0. It then repeats every `TICK_DIV` cycles.
  - After an accept, the next `STEP_EN` is high after the `TICK_DIV`-th edge following the accept edge.
- **Output timing:** all outputs are registered, with no combinational path from any input. `KEY_PULSE` is never high two consecutive cycles.

## Test plan
All scenarios use default parameters and a 10 ns clock.
- **Reset and prescaler:** hold `RST_TOP`=1 for 2 cycles, then release → `S_TOP`=001 and `KEY_PULSE`=0 throughout. `STEP_EN` is high after the 5th, 10th and 15th edges after release, and low otherwise.
- **Clean press:** raise `KEY_IN` before edge N and hold it 20 cycles, then release → a single `KEY_PULSE` after edge N+5, `S_TOP` 001→010 at that edge, and no further pulse while held. The next `STEP_EN` comes 5 edges after the accept.
- **Bounce:** `KEY_IN` high 2 cycles, low 1, high 3, low 1, then high and stable from edge P → exactly one `KEY_PULSE`, after edge P+5.
- **Glitch rejection and wrap:**
  - A 3-cycle high glitch on `KEY_IN` → no pulse and `S_TOP` unchanged.
  - Then 5 clean presses with 10-cycle releases → `S_TOP` sequence 010, 011, 100, 101, 001.
- **Accept on prescaler terminal count:** time the accept to land on the edge where `pc`=4 → `STEP_EN` stays 0 that cycle, and the next `STEP_EN` comes 5 edges later.
- **Reset mid-operation:** press so `S_TOP`=011, then assert `RST_TOP` for 1 cycle while the key is in DEB_PRESS → `S_TOP`=001 and no pulse in the reset cycle. The key, still held, is re-accepted 5 edges after its first post-reset sample, giving `S_TOP`=010.
